// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller: FSM state encoding,
// default sizing and the holdoff counter width.
package irq_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_HOLDOFF = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_SERVICE = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Per-source 2-flop synchronizer followed by a rising-edge detector on the
// synchronized value.
module irq_sync
    import irq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic asyncIn,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= asyncIn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches edge requests, arbitrates lowest-index first
// and sequences RAISE -> HOLDOFF -> SERVICE for one interrupt at a time.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         irq_in,
    input  logic                       mask_we,
    input  logic [NUM_SRC-1:0]         mask_data,
    input  logic                       rti_done,
    output logic                       interrupt,
    output logic [$clog2(NUM_SRC)-1:0] irq_id,
    output logic                       irq_active,
    output logic [NUM_SRC-1:0]         pending,
    output logic                       spurious_rti
);

    localparam int ID_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    irq_state_e         state_r;
    irq_state_e         nextState_s;
    logic [CNT_W-1:0]   holdCnt_r;
    logic [CNT_W-1:0]   holdCntNext_s;
    logic [ID_W-1:0]    irqId_r;
    logic [ID_W-1:0]    irqIdNext_s;
    logic [ID_W-1:0]    winner_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] pendingNext_s;
    logic [NUM_SRC-1:0] clrMask_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic               anyEligible_s;
    logic               interrupt_r;
    logic               irqActive_r;
    logic               spurious_r;

    // Lowest set bit wins; scanning downward lets the lowest index overwrite
    function automatic logic [ID_W-1:0] lowestIndex(input logic [NUM_SRC-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : gSync
        irq_sync uSync (
            .clk     (clk),
            .reset   (reset),
            .asyncIn (irq_in[g]),
            .rise    (rise_s[g])
        );
    end

    // Arbitration over unmasked pending requests
    always_comb begin
        eligible_s    = pending_r & mask_r;
        anyEligible_s = |eligible_s;
        winner_s      = lowestIndex(eligible_s);
    end

    // Pending update: the RAISE cycle retires the winner, a new edge always wins
    always_comb begin
        clrMask_s = {NUM_SRC{1'b0}};
        if (state_r == ST_RAISE) begin
            clrMask_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << irqId_r;
        end else begin
            clrMask_s = {NUM_SRC{1'b0}};
        end
        pendingNext_s = (pending_r & ~clrMask_s) | rise_s;
    end

    // Next-state, holdoff counter and winner capture
    always_comb begin
        nextState_s   = state_r;
        holdCntNext_s = {CNT_W{1'b0}};
        irqIdNext_s   = irqId_r;
        case (state_r)
            ST_IDLE: begin
                if (anyEligible_s) begin
                    nextState_s = ST_RAISE;
                    irqIdNext_s = winner_s;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_RAISE: begin
                nextState_s = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (holdCnt_r == HOLD_LAST) begin
                    nextState_s = ST_SERVICE;
                end else begin
                    holdCntNext_s = holdCnt_r + 4'd1;
                end
            end
            ST_SERVICE: begin
                if (rti_done) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_SERVICE;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and serviced-source index
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            holdCnt_r <= {CNT_W{1'b0}};
            irqId_r   <= {ID_W{1'b0}};
        end else begin
            state_r   <= nextState_s;
            holdCnt_r <= holdCntNext_s;
            irqId_r   <= irqIdNext_s;
        end
    end

    // Request latch and mask register; a mask write only affects arbitration
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_SRC{1'b0}};
            mask_r    <= {NUM_SRC{1'b1}};
        end else begin
            pending_r <= pendingNext_s;
            if (mask_we) begin
                mask_r <= mask_data;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            interrupt_r <= 1'b0;
            irqActive_r <= 1'b0;
            spurious_r  <= 1'b0;
        end else begin
            interrupt_r <= (nextState_s == ST_RAISE);
            irqActive_r <= (nextState_s != ST_IDLE);
            spurious_r  <= spurious_r | (rti_done & (state_r != ST_SERVICE));
        end
    end

    assign interrupt    = interrupt_r;
    assign irq_id       = irqId_r;
    assign irq_active   = irqActive_r;
    assign pending      = pending_r;
    assign spurious_rti = spurious_r;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller with default parameters.
module tb_irq_controller;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_data;
    logic       rti_done;
    logic       interrupt;
    logic [1:0] irq_id;
    logic       irq_active;
    logic [3:0] pending;
    logic       spurious_rti;

    int nChecks = 0;
    int nFail   = 0;

    irq_controller #(.NUM_SRC(4), .HOLDOFF(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .mask_we      (mask_we),
        .mask_data    (mask_data),
        .rti_done     (rti_done),
        .interrupt    (interrupt),
        .irq_id       (irq_id),
        .irq_active   (irq_active),
        .pending      (pending),
        .spurious_rti (spurious_rti)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulseRti();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'b0000; mask_we = 1'b0; mask_data = 4'b0000; rti_done = 1'b0;
        repeat (3) tick();
        check("rst_int", 32'(interrupt), 32'd0);
        check("rst_active", 32'(irq_active), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_spurious", 32'(spurious_rti), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        reset = 1'b0;
        tick();

        // Single request on source 0: latency, pulse width, holdoff length
        irq_in = 4'b0001;
        tick(); tick();
        check("lat_pending_early", 32'(pending), 32'd0);
        tick();
        check("lat_pending", 32'(pending), 32'd1);
        check("lat_no_int", 32'(interrupt), 32'd0);
        tick();
        check("raise_int", 32'(interrupt), 32'd1);
        check("raise_id", 32'(irq_id), 32'd0);
        check("raise_active", 32'(irq_active), 32'd1);
        tick();
        check("int_single", 32'(interrupt), 32'd0);
        check("pending_cleared", 32'(pending), 32'd0);
        check("holdoff_first", 32'(dut.state_r), 32'(ST_HOLDOFF));
        tick(); tick(); tick();
        check("holdoff_last", 32'(dut.state_r), 32'(ST_HOLDOFF));
        tick();
        check("service_entry", 32'(dut.state_r), 32'(ST_SERVICE));
        irq_in = 4'b0000;
        repeat (3) tick();
        check("service_active", 32'(irq_active), 32'd1);
        pulseRti();
        check("rti_active_drop", 32'(irq_active), 32'd0);
        check("rti_no_spurious", 32'(spurious_rti), 32'd0);
        check("rti_idle", 32'(dut.state_r), 32'(ST_IDLE));

        // Simultaneous edges on sources 1 and 2
        irq_in = 4'b0110;
        repeat (4) tick();
        check("prio_int", 32'(interrupt), 32'd1);
        check("prio_id", 32'(irq_id), 32'd1);
        check("prio_pending", 32'(pending), 32'd6);
        tick();
        check("prio_pending_left", 32'(pending), 32'd4);
        repeat (4) tick();
        check("prio_service", 32'(dut.state_r), 32'(ST_SERVICE));
        pulseRti();
        check("b2b_idle_gap", 32'(interrupt), 32'd0);
        check("b2b_idle_active", 32'(irq_active), 32'd0);
        tick();
        check("b2b_int", 32'(interrupt), 32'd1);
        check("b2b_id", 32'(irq_id), 32'd2);
        repeat (5) tick();
        pulseRti();
        check("b2b_done", 32'(irq_active), 32'd0);
        irq_in = 4'b0000;

        // Masked request is held, then released by unmasking
        mask_we = 1'b1; mask_data = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq_in = 4'b0001;
        repeat (6) tick();
        check("mask_pending", 32'(pending), 32'd1);
        check("mask_no_int", 32'(interrupt), 32'd0);
        check("mask_no_active", 32'(irq_active), 32'd0);
        mask_we = 1'b1; mask_data = 4'b1111;
        tick();
        mask_we = 1'b0;
        check("unmask_wait", 32'(interrupt), 32'd0);
        tick();
        check("unmask_int", 32'(interrupt), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd0);
        // Mask write during holdoff does not disturb the service in flight
        tick();
        mask_we = 1'b1; mask_data = 4'b0000;
        tick();
        mask_we = 1'b0;
        repeat (3) tick();
        check("inflight_service", 32'(dut.state_r), 32'(ST_SERVICE));
        check("inflight_active", 32'(irq_active), 32'd1);
        pulseRti();
        mask_we = 1'b1; mask_data = 4'b1111;
        tick();
        mask_we = 1'b0;
        irq_in = 4'b0000;

        // Source 3 re-requests while being serviced
        irq_in = 4'b1000;
        repeat (4) tick();
        check("src3_int", 32'(interrupt), 32'd1);
        check("src3_id", 32'(irq_id), 32'd3);
        irq_in = 4'b0000;
        repeat (5) tick();
        check("src3_service", 32'(dut.state_r), 32'(ST_SERVICE));
        irq_in = 4'b1000;
        repeat (3) tick();
        check("src3_repend", 32'(pending), 32'd8);
        check("src3_no_nest", 32'(interrupt), 32'd0);
        check("src3_still_service", 32'(dut.state_r), 32'(ST_SERVICE));
        pulseRti();
        check("src3_gap", 32'(interrupt), 32'd0);
        tick();
        check("src3_second_int", 32'(interrupt), 32'd1);
        check("src3_second_id", 32'(irq_id), 32'd3);
        repeat (5) tick();
        pulseRti();
        irq_in = 4'b0000;
        check("src3_done", 32'(irq_active), 32'd0);

        // Spurious RTI in IDLE is sticky
        tick();
        pulseRti();
        check("spur_flag", 32'(spurious_rti), 32'd1);
        check("spur_idle", 32'(dut.state_r), 32'(ST_IDLE));
        check("spur_active", 32'(irq_active), 32'd0);
        repeat (5) tick();
        check("spur_sticky", 32'(spurious_rti), 32'd1);

        // Reset during holdoff, then a level held high across reset
        irq_in = 4'b0100;
        repeat (5) tick();
        check("abort_holdoff", 32'(dut.state_r), 32'(ST_HOLDOFF));
        check("abort_active_pre", 32'(irq_active), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_int", 32'(interrupt), 32'd0);
        check("abort_active", 32'(irq_active), 32'd0);
        check("abort_pending", 32'(pending), 32'd0);
        check("abort_spurious", 32'(spurious_rti), 32'd0);
        check("abort_id", 32'(irq_id), 32'd0);
        check("abort_state", 32'(dut.state_r), 32'(ST_IDLE));
        tick();
        check("abort_no_pulse", 32'(interrupt), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("level_pending", 32'(pending), 32'd4);
        check("level_no_int_yet", 32'(interrupt), 32'd0);
        tick();
        check("level_int", 32'(interrupt), 32'd1);
        check("level_id", 32'(irq_id), 32'd2);
        tick();
        check("level_single", 32'(interrupt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, number of external interrupt sources; legal range 2..8.
REQ-002 Parameter HOLDOFF, default 4, cycles between interrupt pulse and SERVICE entry; legal range 1..15.
REQ-003 clk  input  1  single clock, rising edge; all state updates on this edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  NUM_SRC  asynchronous level requests; a rising edge requests service.
REQ-006 mask_we  input  1  mask write strobe.
REQ-007 mask_data  input  NUM_SRC  new mask, 1 = source enabled; loaded when mask_we=1.
REQ-008 rti_done  input  1  one-cycle pulse from core when RTI retires.
REQ-009 interrupt  output  1  one-cycle pulse driving the core interrupt input.
REQ-010 irq_id  output  clog2(NUM_SRC)  index of source being serviced; valid while irq_active=1.
REQ-011 irq_active  output  1  high from RAISE through SERVICE.
REQ-012 pending  output  NUM_SRC  latched, not-yet-serviced requests.
REQ-013 spurious_rti  output  1  sticky: rti_done seen outside SERVICE.

Function
REQ-014 Each irq_in bit passes a 2-flop synchronizer; a 0->1 transition of the synchronized value sets its pending bit. Edge-to-pending latency is 3 cycles.
REQ-015 Set and clear of the same pending bit in one cycle: set wins, bit stays 1.
REQ-016 Eligible = pending AND mask; the lowest eligible index has the highest priority.
REQ-017 FSM states: IDLE, RAISE, HOLDOFF, SERVICE.
REQ-018 IDLE -> RAISE when any eligible bit is 1; irq_id captures the winner on that edge.
REQ-019 RAISE lasts exactly 1 cycle: interrupt=1, pending[irq_id] cleared; next state HOLDOFF.
REQ-020 HOLDOFF counts HOLDOFF cycles on a 4-bit counter, then goes to SERVICE; interrupt=0.
REQ-021 SERVICE -> IDLE on rti_done=1; irq_active drops the following cycle.
REQ-022 One interrupt at a time, no nesting; edges arriving in any state only accumulate in pending.
REQ-023 Back-to-back requests: one IDLE cycle minimum between rti_done and the next RAISE.
REQ-024 Masked pending bits are held, not discarded; they become eligible when unmasked.
REQ-025 A mask write takes effect on the next cycle's arbitration and does not affect an in-flight service.
REQ-026 rti_done in IDLE, RAISE or HOLDOFF is ignored for state and sets spurious_rti.
REQ-027 spurious_rti is cleared only by reset.
REQ-028 interrupt is never high for two consecutive cycles.

Reset
REQ-029 Reset state: FSM=IDLE; pending=0; mask=all ones; irq_id=0; counter=0; synchronizers=0.
REQ-030 Reset outputs: interrupt=0, irq_active=0, spurious_rti=0.
REQ-031 Reset mid-service aborts the service with no interrupt pulse; requests in flight are lost.
REQ-032 After reset release, a level already high on irq_in produces an edge and one request.

Structure
REQ-033 Shared package irq_pkg holds the state enumeration, the NUM_SRC and HOLDOFF defaults, and the counter width.
REQ-034 One sub-module, irq_sync, implements the per-bit 2-flop synchronizer and rising-edge detector; it is instantiated NUM_SRC times.

Verification
REQ-035 Stimulus: irq_in=0001 edge at cycle 10. Response: interrupt pulse at cycle 13, irq_id=0, SERVICE at cycle 18, rti_done at 25 -> irq_active=0 at cycle 26.
REQ-036 Stimulus: edges on sources 2 and 1 in the same cycle. Response: source 1 serviced first; source 2 raised after rti_done plus one IDLE cycle.
REQ-037 Stimulus: mask=1110, then source 0 edge. Response: no interrupt and pending=0001; writing mask=1111 gives a RAISE 2 cycles later.
REQ-038 Stimulus: rti_done pulse in IDLE. Response: spurious_rti=1, state stays IDLE; the flag persists until reset.
REQ-039 Stimulus: reset asserted during HOLDOFF. Response: all outputs at reset values next cycle, and no interrupt pulse is emitted.
REQ-040 Stimulus: source 3 edges again while it is in SERVICE. Response: pending[3]=1, and a second RAISE occurs after rti_done.
